tdc_uart_reporter: RTL
======================

// Module: tdc_uart_reporter
// PURPOSE
//   Consumer of TDC results. Captures each 40-bit measurement pulsed by the TDC core.
//   Frames it as a fixed-length byte packet and serialises it on an 8N1 UART line to the host.
//   Sits between the TDC core's measurement/meas_valid outputs and the FTDI UART RX pin.
//   Provides one-deep buffering plus drop accounting, so no result is silently lost.
// PARAMETERS
//   CLK_HZ     100_000_000  clk frequency in Hz
//   BAUD       115_200      UART bit rate
//   SYNC_BYTE  8'hA5        first byte of every packet
//   CLKS_PER_BIT (localparam) = (CLK_HZ + BAUD/2) / BAUD, which is 868 at the defaults; must be >= 2
// PORTS
//   clk          in   1   system clock (100 MHz); reset is rst_n, synchronous, active-low
//   rst_n        in   1   synchronous active-low reset
//   measurement  in   40  TDC result: [33:6] coarse, [5:0] fine, [39:34] zero
//   meas_valid   in   1   1-cycle strobe; measurement is valid in the same cycle
//   uart_tx      out  1   serial line, idle high
//   busy         out  1   high while a packet is pending or being transmitted
//   drop_count   out  8   results lost to overflow, saturating
// BEHAVIOUR
//   Reset values: uart_tx=1, busy=0, drop_count=0, pending buffer empty, serialiser idle.
//   Reset mid-packet abandons the packet; uart_tx is high on the cycle after the reset edge.
//   Capture:
//     - On meas_valid with pending empty, or being emptied in this same cycle: load measurement into pending and mark it full.
//     - On meas_valid with pending full and not being emptied: discard the result; drop_count++, saturating at 8'hFF.
//   Packet, bytes in order:
//     - SYNC_BYTE
//     - meas[39:32], meas[31:24], meas[23:16], meas[15:8], meas[7:0]
//     - [checksum]; see CONFIGURATION
//   Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT clocks.
//   Bytes within a packet are back-to-back, with no idle gap after the stop bit.
//   Packet FSM: P_IDLE -> P_SEND (byte index 0..N-1) -> P_IDLE.
//     - P_IDLE with pending full: move pending into the packet shift register, clear pending, go to P_SEND with index=0.
//     - P_SEND advances the index when the byte serialiser reports byte done; returns to P_IDLE after the last byte.
//   Byte FSM: B_IDLE -> B_START -> B_DATA (8 bits) -> B_STOP -> B_IDLE.
//     - The baud counter reloads at every bit boundary.
//   Latency: meas_valid in cycle N (serialiser idle) -> pending full at N+1 -> uart_tx falls at N+2.
//   After the last stop bit ends, a result pending at that point starts its start bit within 2 clocks.
//   busy = pending_full | (packet FSM != P_IDLE). It is registered and follows the same latency as the pending flag.
//   Buffering: while packet k is being sent, packet k+1 may wait in pending. A third result arriving then is dropped.
//   Simultaneous events:
//     - meas_valid in the same cycle pending moves to the shift register is accepted, not dropped.
//     - drop_count does not wrap.
// CONFIGURATION
//   Macro TDC_REPORT_CHECKSUM_EN.
//   Defined: one extra byte follows meas[7:0]. It is the XOR of the 5 measurement bytes (SYNC excluded). N=7 bytes, 70 bit times per packet.
//   Undefined: no checksum byte. N=6 bytes, 60 bit times per packet.
// STRUCTURE
//   Shared package tdc_pkg holds:
//     - MEAS_W=40
//     - SYNC_BYTE default
//     - PKT_BYTES (6 or 7, chosen by the macro)
//     - packet FSM state encodings, shared with the host-side model
//   One sub-module, uart_tx_byte. It is the byte serialiser and owns the baud counter and the byte FSM.
//     - Params: CLKS_PER_BIT.
//     - Ports: clk, rst_n, data[7:0], valid, ready, tx.
//     - ready is high only in B_IDLE.
//     - It accepts a byte on valid&ready; tx goes low on the next cycle.
//   The top level holds the pending register, the drop counter, the packet FSM and the byte mux.
// TESTING
//   Bench parameters: CLK_HZ=100, BAUD=10, giving CLKS_PER_BIT=10.
//   T1 Reset:
//     - Stimulus: hold rst_n=0 for 5 clocks.
//     - Required: uart_tx=1, busy=0, drop_count=0 throughout.
//   T2 Single result:
//     - Stimulus: measurement=40'h00_1234_5678 with one meas_valid pulse.
//     - Required: bytes A5 00 12 34 56 78 decoded, each bit 10 clocks wide; busy falls after the last stop bit.
//     - With the macro defined: a 7th byte 0x08 follows.
//   T3 Back-to-back:
//     - Stimulus: second meas_valid (40'h3F) 3 clocks after the first.
//     - Required: two complete packets with no gap; drop_count=0.
//   T4 Overflow:
//     - Stimulus: three meas_valid pulses within 5 clocks.
//     - Required: the first two are sent; the third is lost; drop_count=1.
//     - Then: 300 further excess strobes leave drop_count=FF.
//   T5 Simultaneous:
//     - Stimulus: meas_valid in the exact cycle pending transfers to the shift register.
//     - Required: it is accepted and sent as the next packet; drop_count unchanged.
//   T6 Reset mid-packet:
//     - Stimulus: assert rst_n=0 during the 3rd data byte.
//     - Required: uart_tx=1 on the next cycle and nothing pending afterwards.
//     - Then: a new meas_valid yields a clean full packet.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC result reporter: measurement width, packet
// framing constants, FSM encodings and the packet byte selector.
// Build option: TDC_REPORT_CHECKSUM_EN appends an XOR checksum byte to each packet.
package tdc_pkg;

  localparam int MEAS_W = 40;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

`ifdef TDC_REPORT_CHECKSUM_EN
  localparam int PKT_BYTES = 7;
`else
  localparam int PKT_BYTES = 6;
`endif

  localparam int IDX_W = 3;

  typedef enum logic {
    P_IDLE = 1'b0,
    P_SEND = 1'b1
  } pkt_state_e;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } byte_state_e;

  // Byte idx of a packet: sync first, then the measurement MSB byte first.
  function automatic logic [7:0] pkt_byte(input logic [MEAS_W-1:0] meas,
                                          input logic [IDX_W-1:0]  idx,
                                          input logic [7:0]        sync);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = meas[39:32];
      3'd2:    b = meas[31:24];
      3'd3:    b = meas[23:16];
      3'd4:    b = meas[15:8];
      3'd5:    b = meas[7:0];
`ifdef TDC_REPORT_CHECKSUM_EN
      3'd6:    b = meas[39:32] ^ meas[31:24] ^ meas[23:16] ^ meas[15:8] ^ meas[7:0];
`endif
      default: b = sync;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tdc_uart_reporter_tx_byte.sv
// 8N1 byte serialiser: owns the baud counter and the byte FSM.
// The final clock of the stop bit is spent in B_IDLE with ready high, so a
// byte offered then starts its start bit on the very next clock and bytes
// can run back-to-back with every bit exactly CLKS_PER_BIT clocks wide.
module uart_tx_byte
  import tdc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);

  byte_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d;

  // Byte FSM next state, baud counter reload at every bit boundary, and the
  // registered line level derived from the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    case (state_q)
      B_IDLE: begin
        cnt_d = '0;
        if (valid) begin
          state_d = B_START;
          shift_d = data;
        end
      end
      B_START: begin
        if (cnt_q == BIT_LAST) begin
          state_d  = B_DATA;
          cnt_d    = '0;
          bitIdx_d = '0;
        end
      end
      B_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bitIdx_q == 3'd7) begin
            state_d = B_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end
      end
      B_STOP: begin
        if (cnt_q == STOP_LAST) begin
          state_d = B_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = B_IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      B_START: tx_d = 1'b0;
      B_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset leaves the line idle high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= B_IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign ready = (state_q == B_IDLE);
  assign tx    = tx_q;

endmodule

// File: rtl/tdc_uart_reporter.sv
// TDC result reporter: captures 40-bit measurements into a one-deep pending
// buffer, counts overflow drops, and sends each result as a framed UART packet.
// Build option: TDC_REPORT_CHECKSUM_EN adds an XOR checksum byte (7-byte packets).
module tdc_uart_reporter
  import tdc_pkg::*;
#(
  parameter int          CLK_HZ    = 100_000_000,
  parameter int          BAUD      = 115_200,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MEAS_W-1:0] measurement,
  input  logic              meas_valid,
  output logic              uart_tx,
  output logic              busy,
  output logic [7:0]        drop_count
);

  // Rounded clocks per bit; must come out >= 2 for the serialiser.
  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  logic [MEAS_W-1:0] pendData_q, pendData_d;
  logic              pendFull_q, pendFull_d;
  logic [7:0]        dropCnt_q, dropCnt_d;
  pkt_state_e        pktState_q, pktState_d;
  logic [IDX_W-1:0]  byteIdx_q, byteIdx_d;
  logic [MEAS_W-1:0] pktMeas_q, pktMeas_d;
  logic              busy_q, busy_d;

  logic       popPending;
  logic       startPacket;
  logic       byteValid;
  logic       byteReady;
  logic [7:0] byteData;

  // Packet FSM and byte mux: the next byte is offered the moment the
  // serialiser goes ready, and a waiting result chains straight on after
  // the last byte so consecutive packets have no idle gap.
  always_comb begin
    pktState_d  = pktState_q;
    byteIdx_d   = byteIdx_q;
    pktMeas_d   = pktMeas_q;
    startPacket = 1'b0;
    byteValid   = 1'b0;
    byteData    = pkt_byte(pktMeas_q, byteIdx_q, SYNC_BYTE);
    case (pktState_q)
      P_IDLE: begin
        if (pendFull_q) startPacket = 1'b1;
      end
      P_SEND: begin
        if (byteReady) begin
          if (byteIdx_q != LAST_IDX) begin
            byteIdx_d = byteIdx_q + 1'b1;
            byteValid = 1'b1;
            byteData  = pkt_byte(pktMeas_q, byteIdx_d, SYNC_BYTE);
          end else if (pendFull_q) begin
            startPacket = 1'b1;
          end else begin
            pktState_d = P_IDLE;
          end
        end
      end
      default: pktState_d = P_IDLE;
    endcase

    if (startPacket) begin
      pktMeas_d  = pendData_q;
      byteIdx_d  = '0;
      pktState_d = P_SEND;
      byteValid  = 1'b1;
      byteData   = SYNC_BYTE;
    end
    popPending = startPacket;
  end

  // Pending buffer and saturating drop counter; a strobe in the cycle the
  // buffer empties into the packet register is accepted, not dropped.
  always_comb begin
    pendData_d = pendData_q;
    pendFull_d = pendFull_q;
    dropCnt_d  = dropCnt_q;
    if (meas_valid && (!pendFull_q || popPending)) begin
      pendData_d = measurement;
      pendFull_d = 1'b1;
    end else begin
      if (popPending) pendFull_d = 1'b0;
      if (meas_valid && (dropCnt_q != 8'hFF)) dropCnt_d = dropCnt_q + 8'd1;
    end
  end

  assign busy_d = pendFull_d | (pktState_d != P_IDLE);

  // All reporter state; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pendData_q <= '0;
      pendFull_q <= 1'b0;
      dropCnt_q  <= '0;
      pktState_q <= P_IDLE;
      byteIdx_q  <= '0;
      pktMeas_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      pendData_q <= pendData_d;
      pendFull_q <= pendFull_d;
      dropCnt_q  <= dropCnt_d;
      pktState_q <= pktState_d;
      byteIdx_q  <= byteIdx_d;
      pktMeas_q  <= pktMeas_d;
      busy_q     <= busy_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTxByte (
    .clk  (clk),
    .rst_n(rst_n),
    .data (byteData),
    .valid(byteValid),
    .ready(byteReady),
    .tx   (uart_tx)
  );

  assign busy       = busy_q;
  assign drop_count = dropCnt_q;

endmodule
